bcd_scroll_banner: RTL and testbench

//  N-digit BCD scrolling banner for the seven-segment display path. Shifts the digit
//  row left or right on a programmable prescaled tick, or on a single-step strobe.
//  Two modes: COUNT appends the next or previous decimal digit; ROTATE circulates a

---
 rtl/bcd_scroll_banner_pkg.sv | 32 +++
 rtl/bcd_scroll_banner_if.sv | 19 +
 rtl/bcd_scroll_banner_prescaler.sv | 31 +++
 rtl/bcd_scroll_banner.sv | 117 +++++++++++
 tb/tb_bcd_scroll_banner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_scroll_banner_pkg.sv
// rtl/bcd_scroll_banner_pkg.sv - shared digit constants, mode encoding and BCD helpers
// Ports: none (package).
package bcd_scroll_banner_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic {
        MODE_COUNT  = 1'b0,
        MODE_ROTATE = 1'b1
    } banner_mode_e;

    // Mod-10 increment; an out-of-range source digit restarts at 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        if (d >= DIGIT_MAX) begin
            return 4'd0;
        end
        return d + 4'd1;
    endfunction

    // Mod-10 decrement; 0 wraps to 9, an out-of-range source digit becomes 0.
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        if (d > DIGIT_MAX) begin
            return 4'd0;
        end
        if (d == 4'd0) begin
            return DIGIT_MAX;
        end
        return d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_scroll_banner_if.sv
// rtl/bcd_scroll_banner_if.sv - load channel bundling load_valid and load_data
// Signals: load_valid (load strobe), load_data (digit k at [4k+3:4k]).
// master drives the load, slave (the banner) receives it.
interface bcd_scroll_banner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data
    );

    modport slave (
        input load_valid,
        input load_data
    );
endinterface

// File: rtl/bcd_scroll_banner_prescaler.sv
// rtl/bcd_scroll_banner_prescaler.sv - programmable tick prescaler for the banner
// Ports: clk, reset (sync, active-high), i_enable (run), i_clear (restart at 0),
//        i_div (terminal count), o_tick (combinational, qualified by i_enable).
module bcd_scroll_banner_prescaler #(
    parameter int DIV_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_timer;

    // Using >= rather than == lets a lowered terminal count take effect on the
    // very next enabled cycle instead of waiting for the counter to wrap.
    assign o_tick = i_enable && (r_timer >= i_div);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_enable) begin
            r_timer <= o_tick ? '0 : r_timer + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bcd_scroll_banner.sv
// rtl/bcd_scroll_banner.sv - N-digit BCD scrolling banner (COUNT / ROTATE)
// Ports: clk, reset (sync, active-high), enable (prescaler run), dir (1 = left),
//        mode (0 = COUNT, 1 = ROTATE), step_i (single shift strobe), div_i (tick
//        period - 1), load_if (load_valid/load_data channel), digits_o (digit row),
//        shift_o (pulse when a shift updated the row), load_err_o (pulse after a
//        load that contained a non-BCD nibble).
module bcd_scroll_banner
    import bcd_scroll_banner_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 23
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dir,
    input  logic                          mode,
    input  logic                          step_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    bcd_scroll_banner_if.slave            load_if,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits_o,
    output logic                          shift_o,
    output logic                          load_err_o
);

    localparam int ROW_W = DIGIT_W * NUM_DIGITS;

    // Reset row counts down from the top digit: N=4 shows 0,1,2,3 on digits 3..0.
    function automatic logic [ROW_W-1:0] reset_row();
        logic [ROW_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            v[k*DIGIT_W +: DIGIT_W] = 4'((NUM_DIGITS - 1 - k) % 10);
        end
        return v;
    endfunction

    localparam logic [ROW_W-1:0] RESET_ROW = reset_row();

    logic [ROW_W-1:0]   r_digits;
    logic               r_shift;
    logic               r_load_err;

    logic               w_tick;
    logic               w_shift;
    logic               w_rotate;
    logic [DIGIT_W-1:0] w_top;
    logic [DIGIT_W-1:0] w_bot;
    logic [DIGIT_W-1:0] w_fill_left;
    logic [DIGIT_W-1:0] w_fill_right;
    logic [ROW_W-1:0]   w_shift_row;
    logic [ROW_W-1:0]   w_load_row;
    logic               w_load_bad;

    bcd_scroll_banner_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_clear  (load_if.load_valid),
        .i_div    (div_i),
        .o_tick   (w_tick)
    );

    // A step and a tick in the same cycle merge into one shift.
    assign w_shift  = w_tick | step_i;
    assign w_rotate = (mode == MODE_ROTATE);

    assign w_top = r_digits[ROW_W-1 -: DIGIT_W];
    assign w_bot = r_digits[DIGIT_W-1:0];

    // Digit entering at the vacated end: the wrapped-around digit in ROTATE,
    // the next/previous decimal value in COUNT.
    assign w_fill_left  = w_rotate ? w_top : bcd_inc(w_bot);
    assign w_fill_right = w_rotate ? w_bot : bcd_dec(w_top);

    assign w_shift_row = dir ? {r_digits[ROW_W-DIGIT_W-1:0], w_fill_left}
                             : {w_fill_right, r_digits[ROW_W-1:DIGIT_W]};

    // Non-BCD nibbles are loaded as 0 so COUNT mode never sees them.
    always_comb begin
        w_load_row = '0;
        w_load_bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (load_if.load_data[k*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                w_load_bad = 1'b1;
            end else begin
                w_load_row[k*DIGIT_W +: DIGIT_W] = load_if.load_data[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits   <= RESET_ROW;
            r_shift    <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load_if.load_valid) begin
            r_digits   <= w_load_row;
            r_shift    <= 1'b0;
            r_load_err <= w_load_bad;
        end else if (w_shift) begin
            r_digits   <= w_shift_row;
            r_shift    <= 1'b1;
            r_load_err <= 1'b0;
        end else begin
            r_shift    <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign digits_o   = r_digits;
    assign shift_o    = r_shift;
    assign load_err_o = r_load_err;

endmodule

// File: tb/tb_bcd_scroll_banner.sv
// tb/tb_bcd_scroll_banner.sv - self-checking bench for bcd_scroll_banner
module tb_bcd_scroll_banner;

    localparam int N  = 4;
    localparam int DW = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          dir;
    logic          mode;
    logic          step_i;
    logic [DW-1:0] div_i;
    logic [4*N-1:0] digits_o;
    logic          shift_o;
    logic          load_err_o;

    always #5 clk = ~clk;

    bcd_scroll_banner_if #(.NUM_DIGITS(N)) lif ();

    bcd_scroll_banner #(
        .NUM_DIGITS (N),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .mode       (mode),
        .step_i     (step_i),
        .div_i      (div_i),
        .load_if    (lif),
        .digits_o   (digits_o),
        .shift_o    (shift_o),
        .load_err_o (load_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: row kept as a queue of integers, m_row[0] = digit 0.
    int m_row[$];
    int m_timer;
    int m_val;
    bit m_shift;
    bit m_err;
    bit m_tick;
    bit model_ok = 1'b0;

    function automatic logic [4*N-1:0] pack_row();
        logic [4*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'(m_row[k]);
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_row = {};
            for (int k = 0; k < N; k++) m_row.push_back((N - 1 - k) % 10);
            m_timer  = 0;
            m_shift  = 1'b0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_tick = enable && (m_timer >= int'(div_i));
            if (lif.load_valid) begin
                m_err = 1'b0;
                for (int k = 0; k < N; k++) begin
                    m_val = int'(lif.load_data[4*k +: 4]);
                    if (m_val > 9) begin
                        m_val = 0;
                        m_err = 1'b1;
                    end
                    m_row[k] = m_val;
                end
                m_timer = 0;
                m_shift = 1'b0;
            end else begin
                if (enable) m_timer = m_tick ? 0 : m_timer + 1;
                m_shift = m_tick || step_i;
                m_err   = 1'b0;
                if (m_shift) begin
                    if (dir) begin
                        if (mode) m_val = m_row.pop_back();
                        else begin
                            m_val = (m_row[0] + 1) % 10;
                            void'(m_row.pop_back());
                        end
                        m_row.push_front(m_val);
                    end else begin
                        if (mode) m_val = m_row.pop_front();
                        else begin
                            m_val = (m_row[N-1] + 9) % 10;
                            void'(m_row.pop_front());
                        end
                        m_row.push_back(m_val);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_row",   digits_o,   pack_row());
            check("model_shift", shift_o,    m_shift);
            check("model_err",   load_err_o, m_err);
        end
    end

    task automatic wait_shift(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!shift_o && n < 40);
    endtask

    task automatic do_step();
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1; enable = 1'b0; dir = 1'b1; mode = 1'b0; step_i = 1'b0;
        div_i = '0; lif.load_valid = 1'b0; lif.load_data = '0;
        repeat (2) @(negedge clk);
        check("reset_row",   digits_o,   16'h0123);
        check("reset_shift", shift_o,    1'b0);
        check("reset_err",   load_err_o, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_row", digits_o, 16'h0123);

        // COUNT left with a 3-cycle tick period
        div_i = 2; enable = 1'b1; dir = 1'b1; mode = 1'b0;
        wait_shift(n);
        check("t2_first_gap", n, 3);
        check("t2_row1", digits_o, 16'h1234);
        wait_shift(n);
        check("t2_gap", n, 3);
        check("t2_row2", digits_o, 16'h2345);
        repeat (5) wait_shift(n);
        check("t2_wrap", digits_o, 16'h7890);

        // COUNT right via single steps
        enable = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; dir = 1'b0; mode = 1'b0;
        do_step();
        check("t3_row1",  digits_o, 16'h9012);
        check("t3_shift", shift_o,  1'b1);
        do_step();
        check("t3_row2", digits_o, 16'h8901);

        // Sanitised load, then ROTATE left by steps
        mode = 1'b1; dir = 1'b1;
        lif.load_valid = 1'b1; lif.load_data = 16'h47A1;
        @(negedge clk);
        lif.load_valid = 1'b0;
        check("t4_load_row", digits_o,   16'h4701);
        check("t4_load_err", load_err_o, 1'b1);
        do_step();
        check("t4_rot1", digits_o, 16'h7014);
        do_step();
        check("t4_rot2", digits_o, 16'h0147);

        // Load coincident with step and tick
        enable = 1'b1; div_i = 0; step_i = 1'b1;
        lif.load_valid = 1'b1; lif.load_data = 16'h5678;
        @(negedge clk);
        step_i = 1'b0; lif.load_valid = 1'b0; div_i = 3;
        check("t5_row",   digits_o, 16'h5678);
        check("t5_shift", shift_o,  1'b0);
        wait_shift(n);
        check("t5_timer_cleared", n, 4);
        check("t5_row_after", digits_o, 16'h6785);

        // Lower div below the running timer, then reset mid-run
        enable = 1'b1; div_i = 100; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mode = 1'b0; dir = 1'b1;
        repeat (50) @(negedge clk);
        check("t6_no_shift_yet", digits_o, 16'h0123);
        div_i = 1;
        wait_shift(n);
        check("t6_immediate_tick", n, 1);
        wait_shift(n);
        check("t6_period_a", n, 2);
        wait_shift(n);
        check("t6_period_b", n, 2);
        check("t6_row", digits_o, 16'h3456);
        reset = 1'b1; step_i = 1'b1; lif.load_valid = 1'b1; lif.load_data = 16'h9999;
        @(negedge clk);
        check("t6_reset_row",   digits_o,   16'h0123);
        check("t6_reset_shift", shift_o,    1'b0);
        check("t6_reset_err",   load_err_o, 1'b0);
        reset = 1'b0; step_i = 1'b0; lif.load_valid = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
